regfile_wb_arbiter: RTL and testbench

//   Shares the register file's single write port between two write-back requesters:
//   A = ALU result path, B = load / multi-cycle unit path.

---
 rtl/regfile_wb_arbiter.sv | 51 +++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register file write port between ALU (A) and load unit (B)
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wb_stall,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              last_grant_b
);
  logic              open;
  logic              handshake;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  // Grant in the same cycle as valid; on contention the side that did not win last goes first
  always_comb begin
    open      = rst_n & ~wb_stall;
    a_ready   = open & a_valid & (~b_valid | last_grant_b);
    b_ready   = open & b_valid & (~a_valid | ~last_grant_b);
    handshake = a_ready | b_ready;
    win_addr  = b_ready ? b_addr : a_addr;
    win_data  = b_ready ? b_data : a_data;
  end
  // Register the winning write; writes to register 0 are dropped but still move the priority pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
      last_grant_b    <= 1'b1;
    end else begin
      rf_write_enable <= handshake && (win_addr != '0);
      if (handshake && (win_addr != '0)) begin
        rf_write_addr <= win_addr;
        rf_write_data <= win_data;
      end
      if (handshake) last_grant_b <= b_ready;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model of the arbiter
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst_n, wb_stall;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, rf_write_addr;
  logic [DW-1:0] a_data, b_data, rf_write_data;
  logic          rf_write_enable, last_grant_b;
  int            checks = 0;
  int            errors = 0;
  logic          m_en, m_ptr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wb_stall(wb_stall),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .last_grant_b(last_grant_b)
  );

  always #5 clk = ~clk;

  // Expected winner: 0 none, 1 A, 2 B; on contention the requester that did not win last time
  function automatic int winner();
    if (!rst_n || wb_stall) return 0;
    if (a_valid && b_valid) return m_ptr ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  task automatic drive(input logic r, input logic st,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    rst_n = r; wb_stall = st;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge
  task automatic tick();
    int g;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    g  = winner();
    wa = (g == 2) ? b_addr : a_addr;
    wd = (g == 2) ? b_data : a_data;
    @(posedge clk);
    if (!rst_n) begin
      m_en = 0; m_addr = '0; m_data = '0; m_ptr = 1;
    end else if (g != 0) begin
      m_ptr = (g == 2);
      m_en  = (wa != '0);
      if (m_en) begin m_addr = wa; m_data = wd; end
    end else m_en = 0;
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 1, 5'd7, 32'h1111, 1, 5'd8, 32'h2222);
    repeat (2) begin
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {a_ready, b_ready}); end
      tick();
    end
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data, last_grant_b} !== {1'b0, 5'd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got en=%b addr=%0d data=%h ptr=%b exp 0 0 0 1", rf_write_enable, rf_write_addr, rf_write_data, last_grant_b);
    end
  endtask

  task automatic test_single_a();
    drive(1, 0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin errors++; $display("FAIL single_a_ready got %b exp 10", {a_ready, b_ready}); end
    tick();
    checks++;
    if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_a_write got en=%b addr=%0d data=%h exp 1 3 deadbeef", rf_write_enable, rf_write_addr, rf_write_data);
    end
    drive(1, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    tick();
    checks++;
    if (rf_write_enable !== 1'b0) begin errors++; $display("FAIL idle_en got %b exp 0", rf_write_enable); end
  endtask

  task automatic test_alternate();
    int seq[4] = '{1, 9, 2, 10};
    int ai = 0, bi = 0;
    drive(0, 0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, AW'(1 + ai), DW'(32'hA000 + ai), 1, AW'(9 + bi), DW'(32'hB000 + bi));
      checks++;
      if ({a_ready, b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL alt_grant%0d got %b", k, {a_ready, b_ready});
      end
      if (a_ready) ai++;
      if (b_ready) bi++;
      tick();
      checks++;
      if ({rf_write_enable, rf_write_addr} !== {1'b1, AW'(seq[k])}) begin
        errors++; $display("FAIL alt_addr%0d got en=%b addr=%0d exp 1 %0d", k, rf_write_enable, rf_write_addr, seq[k]);
      end
    end
  endtask

  task automatic test_zero_b();
    drive(1, 0, 1, 5'd2, 32'h5, 0, 5'd0, 32'd0);
    tick();
    checks++;
    if (last_grant_b !== 1'b0) begin errors++; $display("FAIL zero_pre_ptr got %b exp 0", last_grant_b); end
    drive(1, 0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
    checks++;
    if ({a_ready, b_ready} !== 2'b01) begin errors++; $display("FAIL zero_ready got %b exp 01", {a_ready, b_ready}); end
    tick();
    checks++;
    if ({rf_write_enable, last_grant_b} !== 2'b01) begin
      errors++; $display("FAIL zero_write got en=%b ptr=%b exp 0 1", rf_write_enable, last_grant_b);
    end
  endtask

  task automatic test_stall();
    logic p;
    drive(1, 0, 1, 5'd4, 32'h44, 0, 5'd0, 32'd0);
    tick();
    p = m_ptr;
    drive(1, 1, 1, 5'd6, 32'h66, 1, 5'd7, 32'h77);
    checks++;
    if (rf_write_enable !== 1'b1) begin errors++; $display("FAIL stall_prior_write got %b exp 1", rf_write_enable); end
    repeat (3) begin
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready got %b exp 00", {a_ready, b_ready}); end
      tick();
      checks++;
      if ({rf_write_enable, last_grant_b} !== {1'b0, p}) begin
        errors++; $display("FAIL stall_state got en=%b ptr=%b exp 0 %b", rf_write_enable, last_grant_b, p);
      end
    end
    drive(1, 0, 1, 5'd6, 32'h66, 1, 5'd7, 32'h77);
    checks++;
    if ({a_ready, b_ready} !== (p ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL stall_release got %b ptr %b", {a_ready, b_ready}, p);
    end
    tick();
  endtask

  task automatic test_reset_discard();
    drive(1, 0, 1, 5'd5, 32'h55, 0, 5'd0, 32'd0);
    tick();
    checks++;
    if (rf_write_enable !== 1'b1) begin errors++; $display("FAIL discard_pre got %b exp 1", rf_write_enable); end
    drive(0, 0, 1, 5'd5, 32'h55, 0, 5'd0, 32'd0);
    tick();
    checks++;
    if ({rf_write_enable, rf_write_addr, last_grant_b} !== {1'b0, 5'd0, 1'b1}) begin
      errors++; $display("FAIL discard got en=%b addr=%0d ptr=%b exp 0 0 1", rf_write_enable, rf_write_addr, last_grant_b);
    end
  endtask

  task automatic test_random();
    logic av = 0, bv = 0;
    logic [AW-1:0] aa = '0, ba = '0;
    logic [DW-1:0] ad = '0, bd = '0;
    int g;
    for (int i = 0; i < 400; i++) begin
      if (!av && $urandom_range(3) != 0) begin av = 1; aa = AW'($urandom); ad = $urandom; end
      if (!bv && $urandom_range(3) != 0) begin bv = 1; ba = AW'($urandom); bd = $urandom; end
      drive($urandom_range(29) != 0, $urandom_range(4) == 0, av, aa, ad, bv, ba, bd);
      g = winner();
      checks++;
      if ({a_ready, b_ready} !== {g == 1, g == 2}) begin
        errors++; $display("FAIL rand_ready%0d got %b exp %b", i, {a_ready, b_ready}, {g == 1, g == 2});
      end
      tick();
      checks++;
      if ({rf_write_enable, last_grant_b} !== {m_en, m_ptr} ||
          (m_en && {rf_write_addr, rf_write_data} !== {m_addr, m_data})) begin
        errors++;
        $display("FAIL rand_out%0d got en=%b ptr=%b addr=%0d data=%h exp %b %b %0d %h", i,
                 rf_write_enable, last_grant_b, rf_write_addr, rf_write_data, m_en, m_ptr, m_addr, m_data);
      end
      if (g == 1) av = 0;
      if (g == 2) bv = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_alternate();
    test_zero_b();
    test_stall();
    test_reset_discard();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
